// File: rtl/dac_serial_model_p_if.sv
// SPI-side pin bundle of the serial DAC model: driver pins in, analog/status view out.
// The master side drives SYNC_b, DIN and LDAC_b; the slave side is the DAC model itself.
interface dac_serial_model_p_if #(
  parameter int CH_N = 8,
  parameter int RES  = 10
);
  logic                      SYNC_b;
  logic                      DIN;
  logic                      LDAC_b;
  logic [CH_N*(RES+1)-1:0]   vout;
  logic [CH_N-1:0]           pd_o;
  logic [1:0]                ldac_mode_o;
  logic                      frame_done;
  logic                      frame_err;
  logic                      cmd_err;
  logic                      ovr;

  modport master (
    output SYNC_b, DIN, LDAC_b,
    input  vout, pd_o, ldac_mode_o, frame_done, frame_err, cmd_err, ovr
  );

  modport slave (
    input  SYNC_b, DIN, LDAC_b,
    output vout, pd_o, ldac_mode_o, frame_done, frame_err, cmd_err, ovr
  );
endinterface

// File: rtl/dac_serial_model_p.sv
// Parametrised serial multi-channel DAC model: frames decode on the last-bit SCLK edge, vout is combinational from registers.
// No backpressure: every SCLK edge is consumed; status pulses last one cycle and ovr is sticky.
module dac_serial_model_p #(
  parameter int CH_N    = 8,
  parameter int RES     = 10,
  parameter int FRAME_W = 16
) (
  input  logic                    SCLK,
  input  logic                    RST_b,
  dac_serial_model_p_if.slave     bus
);
  localparam int AW  = $clog2(CH_N);
  localparam int VW  = RES + 1;
  localparam int CW  = $clog2(FRAME_W + 1);
  localparam int MSB = FRAME_W - 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_W);

  generate
    if (1 + AW + RES > FRAME_W) begin : g_bad_res
      $fatal(1, "dac_serial_model_p: 1+AW+RES exceeds FRAME_W");
    end
    if (CH_N < 2 || CH_N > FRAME_W - 3) begin : g_bad_ch
      $fatal(1, "dac_serial_model_p: CH_N out of range");
    end
  endgenerate

  logic [FRAME_W-2:0] shift_q;
  logic [CW-1:0]      cnt_q;
  logic [RES-1:0]     inreg_q  [CH_N];
  logic [RES-1:0]     dacreg_q [CH_N];
  logic [CH_N-1:0]    gain_q;
  logic [CH_N-1:0]    pd_q;
  logic [1:0]         mode_q;
  logic               done_q;
  logic               ferr_q;
  logic               cerr_q;
  logic               ovr_q;

  logic [FRAME_W-1:0] frame;
  logic [AW-1:0]      addr;
  logic [RES-1:0]     code;
  logic               addr_ok;
  logic               copy;

  assign frame   = {shift_q, bus.DIN};
  assign addr    = frame[MSB-1 -: AW];
  assign code    = frame[MSB-1-AW -: RES];
  assign addr_ok = (32'(addr) < CH_N);
  // Copy decision uses the pre-edge mode, so a mode write never affects its own edge.
  assign copy    = (mode_q == 2'b00) || (mode_q == 2'b10) ||
                   (mode_q == 2'b01 && !bus.LDAC_b);

  always_ff @(posedge SCLK) begin
    if (!RST_b) begin
      shift_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < CH_N; i++) begin
        inreg_q[i]  <= '0;
        dacreg_q[i] <= '0;
      end
      gain_q  <= '0;
      pd_q    <= '1;
      mode_q  <= 2'b01;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      cerr_q <= 1'b0;

      // Lowest precedence first: decode assignments below override the copy.
      if (copy) begin
        for (int i = 0; i < CH_N; i++) dacreg_q[i] <= inreg_q[i];
      end
      if (mode_q == 2'b10) mode_q <= 2'b01;

      if (!bus.SYNC_b) begin
        if (cnt_q == FULL) begin
          ovr_q <= 1'b1;
        end else begin
          shift_q <= {shift_q[FRAME_W-3:0], bus.DIN};
          cnt_q   <= cnt_q + CW'(1);
        end
        if (cnt_q == LAST) begin
          done_q <= 1'b1;
          if (!frame[MSB]) begin
            if (addr_ok) inreg_q[addr] <= code;
            else         cerr_q <= 1'b1;
          end else begin
            unique case (frame[MSB-1:MSB-2])
              2'b00: gain_q <= frame[CH_N-1:0];
              2'b01: begin
                if (frame[1:0] == 2'b11) cerr_q <= 1'b1;
                else                     mode_q <= frame[1:0];
              end
              2'b10: pd_q <= frame[CH_N-1:0];
              2'b11: begin
                for (int i = 0; i < CH_N; i++) begin
                  inreg_q[i]  <= '0;
                  dacreg_q[i] <= '0;
                end
                if (frame[MSB-3]) begin
                  gain_q <= '0;
                  pd_q   <= '1;
                  mode_q <= 2'b01;
                  ovr_q  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end else begin
        cnt_q <= '0;
        if (cnt_q != '0 && cnt_q < FULL) ferr_q <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < CH_N; i++) begin : g_vout
      assign bus.vout[i*VW +: VW] = pd_q[i]   ? '0 :
                                    gain_q[i] ? {dacreg_q[i], 1'b0} :
                                                {1'b0, dacreg_q[i]};
    end
  endgenerate

  assign bus.pd_o        = pd_q;
  assign bus.ldac_mode_o = mode_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = ferr_q;
  assign bus.cmd_err     = cerr_q;
  assign bus.ovr         = ovr_q;
endmodule
